// File: rtl/pooling_window_buffer.sv
// pooling_window_buffer
//
// Streaming front end for the 2x2 max-pooling stage. Pixels arrive one per
// valid/ready handshake in row-major raster order. Every even row is parked
// in a one-row buffer. On the following odd row, the left pixel of each pair
// is parked in a hold register. The right pixel of the pair completes a 2x2
// window, which is registered onto window_data for the comparator tree.
//
// Parameters:
//   D_WIDTH    - pixel width in bits
//   IMG_WIDTH  - pixels per row (even, >= 2)
//   IMG_HEIGHT - rows per frame (even, >= 2)
//
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   in_valid    - in_data carries a pixel
//   in_ready    - block accepts a pixel this cycle
//   in_data     - pixel value, passed through unmodified
//   out_valid   - window_data carries a complete window
//   out_ready   - downstream takes the window this cycle
//   window_data - packed window, word0 = top-left, word1 = top-right,
//                 word2 = bottom-left, word3 = bottom-right (word0 in LSBs)
//   out_last    - marks the final window of a frame

module pooling_window_buffer #(
  parameter int D_WIDTH    = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [D_WIDTH-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*D_WIDTH-1:0]   window_data,
  output logic                   out_last
);

  // Counter widths. The guards keep the widths legal while the elaboration
  // check below reports a bad geometry.
  localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;

  // Reject geometries that cannot be tiled by non-overlapping 2x2 windows.
  generate
    if ((IMG_WIDTH < 2) || ((IMG_WIDTH % 2) != 0)) begin : g_bad_width
      $error("pooling_window_buffer: IMG_WIDTH must be even and >= 2");
    end
    if ((IMG_HEIGHT < 2) || ((IMG_HEIGHT % 2) != 0)) begin : g_bad_height
      $error("pooling_window_buffer: IMG_HEIGHT must be even and >= 2");
    end
  endgenerate

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [D_WIDTH-1:0] row_buf [IMG_WIDTH];
  logic [D_WIDTH-1:0] hold;

  logic               accept;
  logic               col_last;
  logic               row_last;
  logic               win_load;
  logic [COL_W-1:0]   col_left;
  logic [4*D_WIDTH-1:0] next_window;

  // A new pixel can enter whenever the output register is empty or is being
  // drained this very cycle. This lets the register refill without a bubble.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign col_last = (col == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row == ROW_W'(IMG_HEIGHT - 1));

  // A window completes on the right pixel of a pair (odd col) in the lower
  // row of a row pair (odd row).
  assign win_load = accept && row[0] && col[0];

  // Column of the top-left pixel of the current pair.
  assign col_left = col & ~COL_W'(1);

  assign next_window = {in_data, hold, row_buf[col], row_buf[col_left]};

  // Raster position. It advances only on accepted pixels. It wraps at the end
  // of a frame so the next frame follows with no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Upper row of each row pair. It is not reset because every entry is
  // rewritten on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && !row[0]) begin
      row_buf[col] <= in_data;
    end
  end

  // Bottom-left pixel of the pair in progress. It is written on the even
  // column and consumed on the odd column, so it needs no reset either.
  always_ff @(posedge clk) begin
    if (accept && row[0] && !col[0]) begin
      hold <= in_data;
    end
  end

  // Output register. A freshly completed window takes priority over a drain
  // in the same cycle, so out_valid stays high and the old window is
  // replaced. While stalled, nothing here changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_data <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else if (win_load) begin
      window_data <= next_window;
      out_valid   <= 1'b1;
      out_last    <= row_last && col_last;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pooling_window_buffer.sv
// Testbench for pooling_window_buffer.
// Instance dut_a uses a 4x4 frame and dut_b uses an 8x8 frame. Stimulus
// pushes the expected windows into per-instance queues. Monitors pop a queue
// whenever a window is handed off (out_valid && out_ready).

module tb_pooling_window_buffer;

  localparam int DW = 8;

  typedef struct packed {
    logic [4*DW-1:0] win;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [DW-1:0] a_in_data;
  logic [4*DW-1:0] a_window;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [DW-1:0] b_in_data;
  logic [4*DW-1:0] b_window;

  pooling_window_buffer #(.D_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .window_data(a_window), .out_last(a_out_last)
  );

  pooling_window_buffer #(.D_WIDTH(DW), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .window_data(b_window), .out_last(b_out_last)
  );

  exp_t          exp_a[$];
  exp_t          exp_b[$];
  logic [DW-1:0] a_pix [16];
  logic [DW-1:0] b_pix [64];
  int            checks = 0;
  int            fails = 0;
  int            b_windows = 0;
  logic          b_rand = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Presents pixel idx of a_pix to dut_a and returns just after it is
  // accepted. in_valid is left high so consecutive calls stream without gaps.
  task automatic applyStimulus(input int idx);
    int   r;
    int   c;
    logic ok;
    exp_t e;
    r = idx / 4;
    c = idx % 4;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.win  = {a_pix[idx], a_pix[idx-1], a_pix[idx-4], a_pix[idx-5]};
      e.last = (idx == 15);
      exp_a.push_back(e);
    end
    a_in_valid = 1'b1;
    a_in_data  = a_pix[idx];
    ok = 1'b0;
    for (int w = 0; w < 50 && !ok; w++) begin
      @(negedge clk);
      ok = a_in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) checkOutput("a_accept_timeout", 0, 1);
  endtask

  task automatic sendPixelB(input int idx, input int frame);
    int   r;
    int   c;
    logic ok;
    exp_t e;
    r = idx / 8;
    c = idx % 8;
    while ($urandom_range(0, 1) == 1) begin
      b_in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    b_pix[idx] = DW'($urandom);
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.win  = {b_pix[idx], b_pix[idx-1], b_pix[idx-8], b_pix[idx-9]};
      e.last = (idx == 63);
      exp_b.push_back(e);
    end
    b_in_valid = 1'b1;
    b_in_data  = b_pix[idx];
    ok = 1'b0;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      ok = b_in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) checkOutput("b_accept_timeout", frame, -1);
  endtask

  // Scoreboard monitor for dut_a.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) begin
        checkOutput("a_unexpected_window", a_window, 0);
      end else begin
        e = exp_a.pop_front();
        checkOutput("a_window", a_window, e.win);
        checkOutput("a_last", a_out_last, e.last);
      end
    end
  end

  // Scoreboard monitor for dut_b. It also checks that out_last lands on
  // every 16th window.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && b_out_valid && b_out_ready) begin
      b_windows++;
      if (exp_b.size() == 0) begin
        checkOutput("b_unexpected_window", b_window, 0);
      end else begin
        e = exp_b.pop_front();
        checkOutput("b_window", b_window, e.win);
        checkOutput("b_last_position", b_out_last, (b_windows % 16) == 0);
      end
    end
  end

  // Random downstream backpressure for dut_b.
  always @(posedge clk) begin
    #1;
    if (b_rand) b_out_ready = 1'($urandom_range(0, 1));
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_out_ready = 1'b1;
    #1;
    checkOutput("reset_out_valid", a_out_valid, 0);
    checkOutput("reset_in_ready", a_in_ready, 1);
    checkOutput("reset_window", a_window, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] 4x4 frame 0..15, out_ready high");
    for (int i = 0; i < 16; i++) a_pix[i] = DW'(i);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i);
      checkOutput("a_latency_valid", a_out_valid,
                  ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1));
    end
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("a_queue_empty_t1", exp_a.size(), 0);

    $display("[TB] 4x4 frame with 5-cycle stall after the first window");
    for (int i = 0; i < 6; i++) applyStimulus(i);
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = a_pix[6];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", a_in_ready, 0);
      checkOutput("stall_out_valid", a_out_valid, 1);
      checkOutput("stall_window", a_window, 32'h05040100);
      checkOutput("stall_last", a_out_last, 0);
      @(posedge clk);
      #1;
    end
    a_out_ready = 1'b1;
    for (int i = 6; i < 16; i++) applyStimulus(i);
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("a_queue_empty_t2", exp_a.size(), 0);

    $display("[TB] reset after 6 pixels, then frame 100..115");
    for (int i = 0; i < 6; i++) applyStimulus(i);
    a_in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", a_out_valid, 0);
    checkOutput("midreset_out_last", a_out_last, 0);
    checkOutput("midreset_window", a_window, 0);
    checkOutput("midreset_in_ready", a_in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_hold_window", a_window, 0);
    checkOutput("midreset_hold_in_ready", a_in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) a_pix[i] = DW'(100 + i);
    applyStimulus(0);
    for (int i = 1; i < 6; i++) applyStimulus(i);
    checkOutput("post_reset_first_window", a_window, 32'h69686564);
    for (int i = 6; i < 16; i++) applyStimulus(i);
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("a_queue_empty_t4", exp_a.size(), 0);

    $display("[TB] single 255 at row 3 col 2");
    for (int i = 0; i < 16; i++) a_pix[i] = '0;
    a_pix[14] = 8'd255;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i);
      if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
        logic [DW-1:0] mx;
        mx = '0;
        for (int w = 0; w < 4; w++) begin
          if (a_window[w*DW +: DW] > mx) mx = a_window[w*DW +: DW];
        end
        checkOutput("pool_max", mx, (i == 15) ? 255 : 0);
      end
    end
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("a_queue_empty_t5", exp_a.size(), 0);

    $display("[TB] three 8x8 frames with random bubbles and backpressure");
    b_rand = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 64; i++) sendPixelB(i, f);
    end
    b_in_valid = 1'b0;
    b_rand = 1'b0;
    @(posedge clk);
    #2;
    b_out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("b_window_count", b_windows, 48);
    checkOutput("b_queue_empty", exp_b.size(), 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pooling_window_buffer.md
# pooling_window_buffer

Streaming producer for the pooling layer. Accepts one pixel per handshake in row-major raster order and assembles each non-overlapping 2x2 pooling window into the packed bus format that `max_pooling_unit` consumes (SIZE = 4). It sits between the convolution layer output stream and the max-pooling comparator tree. It buffers one image row internally and applies valid/ready backpressure in both directions.

## Interface

Parameters:
- `D_WIDTH`, default 8: pixel width in bits.
- `IMG_WIDTH`, default 8: pixels per row. Must be even and ≥ 2; any other value is an elaboration error.
- `IMG_HEIGHT`, default 8: rows per frame. Must be even and ≥ 2; any other value is an elaboration error.

Ports (`max_pooling_unit` is instantiated with SIZE = 4):
- `clk`, input, 1 bit: single clock; all logic is on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `in_valid`, input, 1 bit: `in_data` holds a valid pixel.
- `in_ready`, output, 1 bit: the block accepts a pixel this cycle.
- `in_data`, input, `D_WIDTH` bits: pixel value (unsigned).
- `out_valid`, output, 1 bit: `window_data` holds a complete window.
- `out_ready`, input, 1 bit: the downstream block takes the window this cycle.
- `window_data`, output, `4*D_WIDTH` bits: packed window. Word i occupies bits [D_WIDTH*(i+1)-1 : D_WIDTH*i].
  - Word 0 = top-left, word 1 = top-right, word 2 = bottom-left, word 3 = bottom-right.
- `out_last`, output, 1 bit: qualifies `out_valid`; marks the final window of a frame.

## Operation

- Internal state:
  - `col` counter, 0..IMG_WIDTH-1, and `row` counter, 0..IMG_HEIGHT-1.
  - Row buffer of IMG_WIDTH words.
  - Hold register of one word.
  - Output register holding `window_data`, `out_valid` and `out_last`.
- A pixel is accepted when `in_valid && in_ready`. Nothing advances on any other cycle.
- `in_ready = !out_valid || out_ready`. This holds on every cycle, regardless of parity.
- Accepted pixel, even `row`: the pixel is written to `row_buf[col]`.
- Accepted pixel, odd `row`, even `col`: the pixel is written to the hold register.
- Accepted pixel, odd `row`, odd `col`: the output register loads {word0 = `row_buf[col-1]`, word1 = `row_buf[col]`, word2 = hold, word3 = `in_data`} and sets `out_valid` = 1.
  - `out_last` = 1 if `row == IMG_HEIGHT-1 && col == IMG_WIDTH-1`, otherwise 0.
- Output handshake:
  - When `out_valid && out_ready` and no new window loads that cycle, `out_valid` clears.
  - When both happen in the same cycle, the new window replaces the old one and `out_valid` stays 1.
- Counter advance on each accepted pixel:
  - `col` increments.
  - At IMG_WIDTH-1, `col` wraps to 0 and `row` increments.
  - At the end of the frame, `row` wraps to 0.
  - The next frame starts immediately, with no gap cycles and no software action.
- Arithmetic: no arithmetic is performed on pixel data. Values pass through bit-exact. Comparison is done downstream.
- Stability under stall: while `out_valid && !out_ready`, `window_data`, `out_valid` and `out_last` hold constant. `in_ready` = 0 during this time, so no pixel is lost.
- Reset (asserted at any time, including mid-frame):
  - `col`, `row` → 0.
  - `out_valid` → 0, `out_last` → 0, `window_data` → 0.
  - `in_ready` therefore reads 1 during and after reset.
  - The row buffer and hold register are not cleared. They are always rewritten before being read.
  - The first pixel accepted after reset release is the top-left pixel of a new frame.

## Timing

- Latency: the window appears on `window_data` with `out_valid` = 1 in the cycle after the bottom-right pixel is accepted. This is one register stage.
- Throughput:
  - One pixel per cycle when `out_ready` stays high.
  - One window per two accepted pixels on odd rows.
  - IMG_WIDTH·IMG_HEIGHT/4 windows per frame.
- The output register drains and refills in the same cycle. No bubble is inserted under continuous flow.
- Input gaps (`in_valid` = 0) have no effect on state.
- A window is produced only from accepted pixels. Nothing is emitted on even rows.
- `in_ready` is combinational from `out_valid` and `out_ready` only. It never depends on `in_valid`.

## Test plan

- Stream a 4x4 frame with pixels 0..15 (D_WIDTH=8, IMG_WIDTH=4, IMG_HEIGHT=4), `out_ready` held at 1:
  - Windows are {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15} (word0..word3).
  - `out_last` = 1 only on the 4th window.
  - Each window appears one cycle after pixels 5, 7, 13 and 15 are accepted, respectively.
- Same frame with `out_ready` = 0 for 5 cycles after the first window:
  - `window_data` is held at {0,1,4,5}.
  - `in_ready` = 0 throughout the stall.
  - The remaining windows match the first test once `out_ready` rises.
- Random `in_valid` bubbles (50%) and random `out_ready` (50%) over 3 back-to-back 8x8 frames:
  - 48 windows are produced, matching the reference model.
  - `out_last` fires on windows 16, 32 and 48.
- Assert `rst_n` low after 6 pixels of a 4x4 frame, then release and send pixels 100..115:
  - First window is {100,101,104,105}.
  - No window containing pre-reset data is emitted.
  - All outputs are 0 and `in_ready` = 1 while reset is asserted.
- Connect the block to `max_pooling_unit` (SIZE=4) and drive a 4x4 frame of value 255 at position (3,2), all other pixels 0:
  - Pooled outputs are 0, 0, 0, 255.
